// File: rtl/i2c_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | i2c_pkg -- shared state encoding and bus constants for I2C target |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ADDR     = 4'd1,
    ST_ADDR_ACK = 4'd2,
    ST_PTR      = 4'd3,
    ST_PTR_ACK  = 4'd4,
    ST_WR       = 4'd5,
    ST_WR_ACK   = 4'd6,
    ST_RD       = 4'd7,
    ST_RD_ACK   = 4'd8,
    ST_WAIT     = 4'd9
  } i2c_state_e;

  localparam logic       I2C_RW_READ      = 1'b1;
  localparam logic [6:0] I2C_GENERAL_CALL = 7'h00;

endpackage
`default_nettype wire

// File: rtl/i2c_bus_sync.sv
`default_nettype none
// +------------------------------------------------------------------+
// | i2c_bus_sync -- SCL/SDA synchronizers, edge and START/STOP detect |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop,
  output logic sda
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl_s;
  logic                   sda_s;

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  // Chains reset to the idle bus level so release of reset creates no events.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
      scl_rise <= 1'b0;
      scl_fall <= 1'b0;
      start    <= 1'b0;
      stop     <= 1'b0;
      sda      <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
      scl_rise <= scl_s & ~scl_d;
      scl_fall <= ~scl_s & scl_d;
      start    <= scl_s & scl_d & sda_d & ~sda_s;
      stop     <= scl_s & scl_d & ~sda_d & sda_s;
      sda      <= sda_s;
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2c_slave_regs.sv
`default_nettype none
// +------------------------------------------------------------------+
// | i2c_slave_regs -- I2C target exposing a bank of 8-bit registers   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module i2c_slave_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR    = 7'h50,
  parameter int         NREGS       = 16,
  parameter int         SYNC_STAGES = 2,
  localparam int        AW          = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl,
  input  logic          sda_i,
  output logic          sda_oe,
  input  logic [AW-1:0] reg_addr_i,
  output logic [7:0]    reg_dat_o,
  output logic          wr_strobe_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [7:0]    wr_data_o
);

  logic scl_rise, scl_fall, start, stop, sda_s;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .scl     (scl),
    .sda_i   (sda_i),
    .scl_rise(scl_rise),
    .scl_fall(scl_fall),
    .start   (start),
    .stop    (stop),
    .sda     (sda_s)
  );

  i2c_state_e    state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic [AW-1:0] ptr, ptr_n;
  logic          byte_done, byte_done_n;
  logic          master_ack, master_ack_n;
  logic          sda_oe_n;
  logic          wr_en;

  logic [7:0]    regs [NREGS];
  logic [7:0]    byte_in;
  logic [7:0]    rd_byte;
  logic [AW-1:0] ptr_inc;
  logic          last_bit;
  logic          addr_hit;

  assign byte_in   = {shreg[6:0], sda_s};
  assign rd_byte   = regs[ptr];
  assign ptr_inc   = ptr + AW'(1);
  assign last_bit  = (bit_cnt == 3'd7);
  assign addr_hit  = (shreg[7:1] == I2C_ADDR) && (I2C_ADDR != I2C_GENERAL_CALL);
  assign reg_dat_o = regs[reg_addr_i];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      bit_cnt    <= 3'd0;
      shreg      <= 8'h00;
      ptr        <= '0;
      byte_done  <= 1'b0;
      master_ack <= 1'b0;
      sda_oe     <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shreg      <= shreg_n;
      ptr        <= ptr_n;
      byte_done  <= byte_done_n;
      master_ack <= master_ack_n;
      sda_oe     <= sda_oe_n;
    end
  end

  // Byte-level decisions are taken on the SCL fall that follows the 8th rise,
  // which is when the target may legally start driving the ACK slot.
  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    shreg_n      = shreg;
    ptr_n        = ptr;
    byte_done_n  = byte_done;
    master_ack_n = master_ack;
    sda_oe_n     = sda_oe;
    wr_en        = 1'b0;
    if (stop) begin
      state_n     = ST_IDLE;
      sda_oe_n    = 1'b0;
      bit_cnt_n   = 3'd0;
      byte_done_n = 1'b0;
    end else if (start) begin
      state_n     = ST_ADDR;
      bit_cnt_n   = 3'd0;
      byte_done_n = 1'b0;
    end else begin
      case (state)
        ST_ADDR, ST_PTR, ST_WR: begin
          if (scl_rise) begin
            shreg_n   = byte_in;
            bit_cnt_n = bit_cnt + 3'd1;
            if (last_bit) begin
              byte_done_n = 1'b1;
              if (state == ST_PTR) begin
                ptr_n = byte_in[AW-1:0];
              end
              if (state == ST_WR) begin
                wr_en = 1'b1;
                ptr_n = ptr_inc;
              end
            end
          end else if (scl_fall && byte_done) begin
            byte_done_n = 1'b0;
            if (state == ST_ADDR && !addr_hit) begin
              state_n = ST_WAIT;
            end else begin
              sda_oe_n = 1'b1;
              case (state)
                ST_ADDR: state_n = ST_ADDR_ACK;
                ST_PTR:  state_n = ST_PTR_ACK;
                default: state_n = ST_WR_ACK;
              endcase
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_n = 3'd0;
            if (shreg[0] == I2C_RW_READ) begin
              state_n  = ST_RD;
              shreg_n  = rd_byte;
              ptr_n    = ptr_inc;
              sda_oe_n = ~rd_byte[7];
            end else begin
              state_n  = ST_PTR;
              sda_oe_n = 1'b0;
            end
          end
        end
        ST_PTR_ACK, ST_WR_ACK: begin
          if (scl_fall) begin
            state_n   = ST_WR;
            bit_cnt_n = 3'd0;
            sda_oe_n  = 1'b0;
          end
        end
        ST_RD: begin
          if (scl_rise) begin
            bit_cnt_n = bit_cnt + 3'd1;
            if (last_bit) begin
              byte_done_n = 1'b1;
            end
          end else if (scl_fall) begin
            if (byte_done) begin
              byte_done_n = 1'b0;
              sda_oe_n    = 1'b0;
              state_n     = ST_RD_ACK;
            end else begin
              shreg_n  = {shreg[6:0], 1'b0};
              sda_oe_n = ~shreg[6];
            end
          end
        end
        ST_RD_ACK: begin
          if (scl_rise) begin
            master_ack_n = ~sda_s;
          end else if (scl_fall) begin
            bit_cnt_n = 3'd0;
            if (master_ack) begin
              state_n  = ST_RD;
              shreg_n  = rd_byte;
              ptr_n    = ptr_inc;
              sda_oe_n = ~rd_byte[7];
            end else begin
              state_n = ST_WAIT;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= 8'h00;
      end
      wr_strobe_o <= 1'b0;
      wr_addr_o   <= '0;
      wr_data_o   <= 8'h00;
    end else begin
      wr_strobe_o <= wr_en;
      if (wr_en) begin
        regs[ptr] <= byte_in;
        wr_addr_o <= ptr;
        wr_data_o <= byte_in;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_regs.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_i2c_slave_regs -- bit-banged I2C master against a register map |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_i2c_slave_regs;

  localparam int NREGS = 16;
  localparam int AW    = 4;
  localparam int Q     = 80;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          scl = 1'b1;
  logic          sda_m = 1'b1;
  logic          sda_oe;
  wire           sda_line;
  logic [AW-1:0] reg_addr = '0;
  logic [7:0]    reg_dat;
  logic          wr_strobe;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;

  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_regs #(
    .I2C_ADDR   (7'h50),
    .NREGS      (NREGS),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .rst        (rst_n),
    .scl        (scl),
    .sda_i      (sda_line),
    .sda_oe     (sda_oe),
    .reg_addr_i (reg_addr),
    .reg_dat_o  (reg_dat),
    .wr_strobe_o(wr_strobe),
    .wr_addr_o  (wr_addr),
    .wr_data_o  (wr_data)
  );

  int unsigned vectors = 0;
  int unsigned misses  = 0;

  // Bus observers: strobe log and a count of cycles the target pulls SDA.
  int unsigned   oe_cnt  = 0;
  int unsigned   obs_cnt = 0;
  logic [11:0]   obs_log [256];
  always @(negedge clk) begin
    if (sda_oe) oe_cnt++;
    if (wr_strobe) begin
      obs_log[obs_cnt[7:0]] = {wr_addr, wr_data};
      obs_cnt++;
    end
  end

  // Transaction-level reference: register array, pointer, expected strobes.
  logic [7:0]  mregs [NREGS];
  int          mptr = 0;
  logic [11:0] exp_q [$];
  int unsigned rd_idx = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      misses++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic clock_bit(input logic d, output logic s);
    sda_m = d;  #Q;
    scl = 1'b1; #Q;
    s = sda_line; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; #Q;
    scl = 1'b1;   #Q;
    sda_m = 1'b0; #Q;
    scl = 1'b0;   #Q;
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; #Q;
    scl = 1'b1;   #Q;
    sda_m = 1'b1; #Q;
    #Q;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    logic s;
    for (int i = 7; i > 7 - n; i--) clock_bit(b[i], s);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic ack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      b[i] = s;
    end
    clock_bit(~ack, s);
  endtask

  task automatic check_strobes;
    check("strobe_count", obs_cnt - rd_idx, exp_q.size());
    while (exp_q.size() > 0) begin
      logic [11:0] e;
      e = exp_q.pop_front();
      if (rd_idx < obs_cnt) begin
        check("strobe_addr_data", obs_log[rd_idx[7:0]], e);
        rd_idx++;
      end
    end
    rd_idx = obs_cnt;
  endtask

  task automatic check_all_regs;
    for (int i = 0; i < NREGS; i++) begin
      reg_addr = AW'(i);
      #1;
      check("local_read", reg_dat, mregs[i]);
    end
  endtask

  task automatic do_write(input int p, input logic [7:0] data [$]);
    logic ack;
    logic [7:0] pb;
    pb = p[7:0];
    i2c_start;
    send_byte(8'hA0, ack); check("wr_addr_ack", ack, 1);
    send_byte(pb, ack);    check("ptr_ack", ack, 1);
    mptr = p % NREGS;
    foreach (data[i]) begin
      send_byte(data[i], ack);
      check("data_ack", ack, 1);
      mregs[mptr] = data[i];
      exp_q.push_back({AW'(mptr), data[i]});
      mptr = (mptr + 1) % NREGS;
    end
    i2c_stop;
    check_strobes;
  endtask

  task automatic do_read(input logic set_ptr, input int p, input int n);
    logic ack;
    logic [7:0] b;
    logic [7:0] pb;
    pb = p[7:0];
    if (set_ptr) begin
      i2c_start;
      send_byte(8'hA0, ack); check("wr_addr_ack", ack, 1);
      send_byte(pb, ack);    check("ptr_ack", ack, 1);
      mptr = p % NREGS;
    end
    i2c_start;
    send_byte(8'hA1, ack); check("rd_addr_ack", ack, 1);
    for (int k = 0; k < n; k++) begin
      recv_byte(k < n - 1, b);
      check("read_data", b, mregs[mptr]);
      mptr = (mptr + 1) % NREGS;
    end
    check("release_after_nack", sda_oe, 0);
    i2c_stop;
  endtask

  task automatic wrong_addr(input logic [7:0] a);
    logic ack;
    int unsigned oe0;
    oe0 = oe_cnt;
    i2c_start;
    send_byte(a, ack); check("foreign_addr_nack", ack, 0);
    send_byte(8'h02, ack); check("wait_nack", ack, 0);
    send_byte(8'hEE, ack); check("wait_nack", ack, 0);
    i2c_stop;
    check("sda_never_driven", oe_cnt - oe0, 0);
    check_strobes;
    check_all_regs;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete, vectors=%0d", vectors);
    $fatal(1);
  end

  initial begin
    logic [7:0] dq [$];
    logic ack;
    int n;
    for (int i = 0; i < NREGS; i++) mregs[i] = 8'h00;

    // Reset state
    repeat (5) @(posedge clk);
    #1;
    check("rst_sda_oe", sda_oe, 0);
    check("rst_strobe", wr_strobe, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check_all_regs;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Basic write
    dq.delete(); dq.push_back(8'h5A); dq.push_back(8'hC3);
    do_write(3, dq);
    reg_addr = 4'd4; #1;
    check("reg4_after_write", reg_dat, 8'hC3);

    // Combined read with repeated START
    do_read(1'b1, 3, 2);

    // Foreign address and general call
    wrong_addr(8'hA2);
    wrong_addr(8'h00);

    // Pointer wrap and upper pointer bits ignored
    dq.delete(); dq.push_back(8'h11); dq.push_back(8'h22);
    do_write(8'h0F, dq);
    reg_addr = 4'd15; #1; check("wrap_reg15", reg_dat, 8'h11);
    reg_addr = 4'd0;  #1; check("wrap_reg0", reg_dat, 8'h22);
    dq.delete(); dq.push_back(8'h77);
    do_write(8'hF5, dq);
    reg_addr = 4'd5; #1; check("ptr_f5_reg5", reg_dat, 8'h77);

    // STOP after 4 bits of a data byte: no write, pointer stays put
    i2c_start;
    send_byte(8'hA0, ack); check("wr_addr_ack", ack, 1);
    send_byte(8'h07, ack); check("ptr_ack", ack, 1);
    mptr = 7;
    send_bits(8'hFF, 4);
    i2c_stop;
    check_strobes;
    do_read(1'b0, 0, 1);

    // START in the middle of an address byte
    i2c_start;
    send_bits(8'hA0, 4);
    dq.delete(); dq.push_back(8'h96);
    do_write(9, dq);
    do_read(1'b1, 9, 1);

    // Reset while the target drives a 0 data bit
    dq.delete(); dq.push_back(8'h35);
    do_write(2, dq);
    i2c_start;
    send_byte(8'hA0, ack); check("wr_addr_ack", ack, 1);
    send_byte(8'h02, ack); check("ptr_ack", ack, 1);
    i2c_start;
    send_byte(8'hA1, ack); check("rd_addr_ack", ack, 1);
    check("drives_zero_bit", sda_oe, 1);
    rst_n = 1'b0;
    #1;
    check("async_release", sda_oe, 0);
    for (int i = 0; i < NREGS; i++) mregs[i] = 8'h00;
    mptr = 0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check("rst_strobe", wr_strobe, 0);
    check_all_regs;
    sda_m = 1'b1;
    scl = 1'b1;
    #Q;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    rd_idx = obs_cnt;
    dq.delete(); dq.push_back(8'hB4);
    do_write(9, dq);
    do_read(1'b1, 9, 1);

    // Randomized transactions
    for (int t = 0; t < 14; t++) begin
      n = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1) begin
        dq.delete();
        for (int k = 0; k < n; k++) dq.push_back(8'($urandom));
        do_write(int'($urandom_range(0, 255)), dq);
      end else begin
        do_read(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), n);
      end
      reg_addr = AW'($urandom);
      #1;
      check("random_local_read", reg_dat, mregs[reg_addr]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
`default_nettype wire
